// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Round-robin option is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MEM_WORDS = 128;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_WORDS);

  function automatic logic addr_bad(
    input logic [31:0] a,
    input logic [31:0] lim
  );
    return (a[1:0] != 2'b00) || (a >= lim);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection between fetch and data ports.
// MEM_ARB_RR_EN: both requesting -> port not granted last wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic i_last_grant,
`endif
  output logic o_valid,
  output logic o_port
);

  // Pick a winner among the active requests
  always_comb begin
    o_valid = i_req | d_req;
    o_port  = PORT_I;
    unique case (1'b1)
      (i_req & d_req): begin
`ifdef MEM_ARB_RR_EN
        o_port = (i_last_grant == PORT_I) ? PORT_D : PORT_I;
`else
        o_port = PORT_D;
`endif
      end
      (d_req & ~i_req): o_port = PORT_D;
      default:          o_port = PORT_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port sequencer for the edge-strobed data memory.
// MEM_ARB_RR_EN enables round-robin grant with a last-grant register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_trigWrite,
  output logic              mem_trigRead,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              busy
);

  localparam logic [31:0] LIM = 32'(4 * (2 ** ADDR_W));

  state_t r_state, w_state_nxt;
  logic r_port, w_port_nxt;
  logic r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic r_trd, w_trd_nxt;
  logic r_twr, w_twr_nxt;
  logic r_iack, w_iack_nxt;
  logic r_dack, w_dack_nxt;
  logic r_ierr, w_ierr_nxt;
  logic r_derr, w_derr_nxt;
  logic [DATA_W-1:0] r_irdata, w_irdata_nxt;
  logic [DATA_W-1:0] r_drdata, w_drdata_nxt;
  logic r_busy;

  logic w_gnt_valid;
  logic w_gnt_port;
  logic [31:0] w_sel_addr;
  logic w_sel_err;

`ifdef MEM_ARB_RR_EN
  logic r_last, w_last_nxt;
`endif

  mem_arb_grant u_grant (
    .i_req        (i_req),
    .d_req        (d_req),
`ifdef MEM_ARB_RR_EN
    .i_last_grant (r_last),
`endif
    .o_valid      (w_gnt_valid),
    .o_port       (w_gnt_port)
  );

  assign w_sel_addr = (w_gnt_port == PORT_D) ? d_addr : i_addr;
  assign w_sel_err  = addr_bad(w_sel_addr, LIM);

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_port_nxt   = r_port;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_trd_nxt    = 1'b0;
    w_twr_nxt    = 1'b0;
    w_iack_nxt   = 1'b0;
    w_dack_nxt   = 1'b0;
    w_ierr_nxt   = 1'b0;
    w_derr_nxt   = 1'b0;
    w_irdata_nxt = r_irdata;
    w_drdata_nxt = r_drdata;
`ifdef MEM_ARB_RR_EN
    w_last_nxt   = r_last;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_port_nxt = w_gnt_port;
          w_we_nxt   = (w_gnt_port == PORT_D) && d_we;
`ifdef MEM_ARB_RR_EN
          w_last_nxt = w_gnt_port;
`endif
          if (w_sel_err) begin
            w_state_nxt = DONE;
            if (w_gnt_port == PORT_D) begin
              w_dack_nxt   = 1'b1;
              w_derr_nxt   = 1'b1;
              w_drdata_nxt = '0;
            end else begin
              w_iack_nxt   = 1'b1;
              w_ierr_nxt   = 1'b1;
              w_irdata_nxt = '0;
            end
          end else begin
            w_state_nxt = SETUP;
            w_addr_nxt  = w_sel_addr[ADDR_W+1:2];
            if (w_we_nxt) w_wdata_nxt = d_wdata;
          end
        end
      end
      SETUP: begin
        w_state_nxt = STROBE;
        w_trd_nxt   = ~r_we;
        w_twr_nxt   = r_we;
      end
      STROBE: w_state_nxt = CAPTURE;
      CAPTURE: begin
        w_state_nxt = DONE;
        if (r_port == PORT_D) begin
          w_dack_nxt   = 1'b1;
          w_drdata_nxt = r_we ? '0 : mem_readData;
        end else begin
          w_iack_nxt   = 1'b1;
          w_irdata_nxt = mem_readData;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_port   <= PORT_I;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_trd    <= 1'b0;
      r_twr    <= 1'b0;
      r_iack   <= 1'b0;
      r_dack   <= 1'b0;
      r_ierr   <= 1'b0;
      r_derr   <= 1'b0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_port   <= w_port_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_trd    <= w_trd_nxt;
      r_twr    <= w_twr_nxt;
      r_iack   <= w_iack_nxt;
      r_dack   <= w_dack_nxt;
      r_ierr   <= w_ierr_nxt;
      r_derr   <= w_derr_nxt;
      r_irdata <= w_irdata_nxt;
      r_drdata <= w_drdata_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember which port won the last grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_last <= PORT_I;
    else          r_last <= w_last_nxt;
  end
`endif

  assign i_ack         = r_iack;
  assign i_rdata       = r_irdata;
  assign i_err         = r_ierr;
  assign d_ack         = r_dack;
  assign d_rdata       = r_drdata;
  assign d_err         = r_derr;
  assign mem_address   = r_addr;
  assign mem_writeData = r_wdata;
  assign mem_trigWrite = r_twr;
  assign mem_trigRead  = r_trd;
  assign busy          = r_busy;

endmodule
